quad_decoder: RTL

//   Decodes a two-phase quadrature signal pair (A/B) from an incremental encoder into a

---
 rtl/quad_decoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// quad_decoder
//   Turns the A/B phase pair of an incremental encoder into a wrapping up/down
//   position count plus a direction flag. Each phase is synchronised, then
//   glitch-filtered, and the filtered pair is decoded as a Gray-code walk.
//   The decoder flags any jump that changes both phases in one step.
//
// Parameters
//   CNT_W        width of o_cnt; the count wraps modulo 2^CNT_W
//   SYNC_STAGES  synchroniser flops per input (>= 2)
//   FILT_LEN     consecutive equal synced samples needed to accept a new level (>= 1)
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_a, i_b   encoder phases, asynchronous to i_clk
//   i_en       1 = decode steps; 0 = only track the phase
//   i_clr      synchronous clear of o_cnt
//   i_err_clr  synchronous clear of o_err (a same-cycle illegal jump wins)
//   o_cnt      position count
//   o_dir      direction of the last accepted step (0 = up, 1 = down)
//   o_step     one-cycle pulse per accepted step
//   o_err      sticky illegal-transition flag
module quad_decoder #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_err
);

  localparam int FCW    = $clog2(FILT_LEN + 1);
  localparam int SETTLE = SYNC_STAGES + FILT_LEN;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             synced;
  logic [1:0]             filt;
  logic [FCW-1:0]         fcnt [2];
  logic                   filters_idle;

  state_t         state, state_n;
  logic [1:0]     prev, prev_n;
  logic [SW-1:0]  settle_cnt, settle_n;
  logic [CNT_W-1:0] cnt_n;
  logic           dir_n, step_n, err_n;
  logic           illegal;
  logic [1:0]     delta;

  // Bit 1 carries phase A and bit 0 phase B, so {A,B} reads directly as the pair.
  assign synced       = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign filters_idle = (fcnt[0] == '0) && (fcnt[1] == '0);

  // Gray code to a 2-bit position (00,01,11,10 -> 0,1,2,3) so that a step is
  // simply a position difference of +1 or -1 modulo 4, and 2 means both phases moved.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Synchroniser chains for the two asynchronous encoder phases.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_b};
    end
  end

  // Per-channel filter: a new level is taken only after FILT_LEN consecutive
  // differing samples; any sample matching the current level restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt <= '0;
      for (int ch = 0; ch < 2; ch++) fcnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (synced[ch] != filt[ch]) begin
          if (fcnt[ch] == FCW'(FILT_LEN - 1)) begin
            filt[ch] <= synced[ch];
            fcnt[ch] <= '0;
          end else begin
            fcnt[ch] <= fcnt[ch] + FCW'(1);
          end
        end else begin
          fcnt[ch] <= '0;
        end
      end
    end
  end

  // State, previous phase and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_INIT;
      prev       <= '0;
      settle_cnt <= '0;
      o_cnt      <= '0;
      o_dir      <= 1'b0;
      o_step     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      settle_cnt <= settle_n;
      o_cnt      <= cnt_n;
      o_dir      <= dir_n;
      o_step     <= step_n;
      o_err      <= err_n;
    end
  end

  // Next-state and decode logic. After reset the filtered levels still read 0
  // until the pin state has crossed the synchroniser and filter, so S_INIT
  // waits that long (and for both filters to be quiet) before capturing the
  // starting phase; otherwise a pin resting at 11 would look like an illegal jump.
  always_comb begin
    state_n  = state;
    prev_n   = prev;
    settle_n = settle_cnt;
    cnt_n    = o_cnt;
    dir_n    = o_dir;
    step_n   = 1'b0;
    err_n    = o_err;
    illegal  = 1'b0;
    delta    = gray_pos(filt) - gray_pos(prev);

    case (state)
      S_INIT: begin
        if (settle_cnt != SW'(SETTLE)) begin
          settle_n = settle_cnt + SW'(1);
        end else if (filters_idle) begin
          prev_n  = filt;
          state_n = S_TRACK;
        end
      end
      S_TRACK: begin
        prev_n = filt;
        if (i_en) begin
          case (delta)
            2'd1: begin
              cnt_n  = o_cnt + CNT_W'(1);
              dir_n  = 1'b0;
              step_n = 1'b1;
            end
            2'd3: begin
              cnt_n  = o_cnt - CNT_W'(1);
              dir_n  = 1'b1;
              step_n = 1'b1;
            end
            2'd2:    illegal = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_n = S_INIT;
    endcase

    // Clear overrides the count only; direction and step still report the step.
    if (i_clr) cnt_n = '0;
    if (i_err_clr) err_n = 1'b0;
    if (illegal) err_n = 1'b1;
  end

endmodule
